fir_filter: RTL and testbench
=============================

FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 Parameter DATA_W, default 16, width of the signed input sample.
REQ-002 Parameter COEF_W, default 16, width of each signed coefficient.
REQ-003 Parameter NUM_TAPS, default 7, number of filter taps (range 1..64).
REQ-004 Parameter COEFFS, default {1024, 2048, 3072, 4096, 3072, 2048, 1024} (tap 0 first), signed coefficient set; it puts zeros at fs/4 and fs/2, with DC gain 16384.
REQ-005 Parameter OUT_W, default 48, width of the output bus.
REQ-006 Port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 Port aresetn, input, 1, asynchronous active-low reset.
REQ-008 Port s_axis_data_tvalid, input, 1, input sample valid.
REQ-009 Port s_axis_data_tready, output, 1, block ready to accept a sample.
REQ-010 Port s_axis_data_tdata, input, DATA_W, signed two's-complement input sample.
REQ-011 Port m_axis_data_tvalid, output, 1, output sample valid, held high for one cycle per result.
REQ-012 Port m_axis_data_tdata, output, OUT_W, signed filter result, sign-extended to OUT_W.

Function
REQ-013 A sample is accepted on a rising edge where tvalid and tready are both 1; the delay line shifts only on acceptance.
REQ-014 s_axis_data_tready is 1 from the first rising edge after aresetn deasserts and stays 1; the block never applies backpressure.
REQ-015 Output: y[n] = sum over k = 0..NUM_TAPS-1 of COEFFS[k] * x[n-k], where x[n] is the n-th accepted sample and pre-history samples are 0.
REQ-016 Arithmetic is full precision: no rounding, truncation or saturation. The internal width is DATA_W + COEF_W + ceil(log2(NUM_TAPS)), which is 35 bits at default parameters; the result is sign-extended to OUT_W.
REQ-017 Latency is fixed at 2 clocks. For a sample accepted at edge k, m_axis_data_tvalid is 1 and tdata holds y[n] after edge k+2.
REQ-018 Exactly one output is produced per accepted sample, in order; gaps in input tvalid produce equal gaps in output tvalid.
REQ-019 m_axis_data_tdata holds its last value while m_axis_data_tvalid is 0.
REQ-020 The master side has no tready; downstream logic must accept every valid output.
REQ-021 Back-to-back accepted samples on consecutive clocks yield outputs on consecutive clocks (throughput of 1 sample per clock).

Reset
REQ-022 While aresetn is 0, outputs are: s_axis_data_tready = 0, m_axis_data_tvalid = 0, m_axis_data_tdata = 0.
REQ-023 Reset clears all delay-line and pipeline registers; results of samples in flight are discarded.
REQ-024 A reset asserted mid-stream takes effect immediately (asynchronous). After release, filtering restarts with zero history.
REQ-025 Deassertion of aresetn is synchronized to aclk before s_axis_data_tready rises.

Verification
REQ-026 Reset check: hold aresetn = 0 for 2 clocks, then release. Required: tready = 0 and m_tvalid = 0 during reset; tready = 1 one edge after release.
REQ-027 Impulse: drive 1 followed by 7 zeros, continuous valid. Required outputs: 1024, 2048, 3072, 4096, 3072, 2048, 1024, 0, with the first output 2 clocks after the impulse is accepted.
REQ-028 Step: drive a constant 0x2000 for 10 samples. Required: outputs ramp, then settle from output 7 onward at 134217728 (0x0000_0800_0000).
REQ-029 fs/4 tone: drive the repeating sequence 8192, 0, -8192, 0 for 16 samples. Required: every output from the 7th onward is exactly 0.
REQ-030 Negative full scale: drive -32768 constantly. Required steady output is -536870912 (0xFFFF_E000_0000), correctly sign-extended.
REQ-031 Gapped valid: repeat the impulse test with tvalid deasserted every other clock. Required: the same output values, each m_tvalid pulse 2 clocks after its input; then assert reset mid-stream and confirm the next impulse response starts cleanly at 1024.

Source files
------------

// File: rtl/fir_filter.sv
// Direct-form FIR filter with a stream-style slave input and master output.
// Full-precision signed multiply-accumulate, fixed 2-clock latency, one sample per clock.
module fir_filter #(
    parameter int                       DATA_W   = 16,
    parameter int                       COEF_W   = 16,
    parameter int                       NUM_TAPS = 7,
    parameter logic signed [COEF_W-1:0] COEFFS [NUM_TAPS] = '{
        COEF_W'(1024), COEF_W'(2048), COEF_W'(3072), COEF_W'(4096),
        COEF_W'(3072), COEF_W'(2048), COEF_W'(1024)
    },
    parameter int                       OUT_W    = 48
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    input  logic [DATA_W-1:0] s_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    output logic [OUT_W-1:0]  m_axis_data_tdata
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);

    logic                     r_ready;
    logic                     w_accept;
    logic signed [DATA_W-1:0] r_taps [NUM_TAPS];
    logic                     r_tap_valid;
    logic signed [PROD_W-1:0] r_prod [NUM_TAPS];
    logic                     r_prod_valid;
    logic signed [ACC_W-1:0]  w_sum;
    logic [OUT_W-1:0]         r_out;
    logic                     r_out_valid;

    // NOTE: reset lifts asynchronously at any time, so tready comes from a flop that only
    // sets on a clock edge; acceptance therefore never begins on the edge reset releases.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    assign w_accept = s_axis_data_tvalid & r_ready;

    // Stage 0: delay line, tap k holds x[n-k]; it moves only when a sample is accepted.
    // NOTE: the delay line is a register array, not a RAM, so it is cleared by reset to
    // give every restart a zero history.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_taps[k] <= '0;
            end
            r_tap_valid <= 1'b0;
        end else begin
            r_tap_valid <= w_accept;
            if (w_accept) begin
                r_taps[0] <= $signed(s_axis_data_tdata);
                for (int k = 1; k < NUM_TAPS; k++) begin
                    r_taps[k] <= r_taps[k-1];
                end
            end
        end
    end

    // Stage 1: one registered product per tap; operands are sign-extended before multiplying.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_prod[k] <= '0;
            end
            r_prod_valid <= 1'b0;
        end else begin
            r_prod_valid <= r_tap_valid;
            if (r_tap_valid) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    r_prod[k] <= PROD_W'(r_taps[k]) * PROD_W'(COEFFS[k]);
                end
            end
        end
    end

    // NOTE: combinational accumulation uses blocking assignments so each iteration sees
    // the running total; the default assignment first keeps this free of latches.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_sum = w_sum + ACC_W'(r_prod[k]);
        end
    end

    // Stage 2: output register; data holds its last value between valid pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_prod_valid;
            if (r_prod_valid) begin
                r_out <= OUT_W'(w_sum);
            end
        end
    end

    assign s_axis_data_tready = r_ready;
    assign m_axis_data_tvalid = r_out_valid;
    assign m_axis_data_tdata  = r_out;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: stimulus pushes hand-computed results with their due cycle,
// a negedge monitor pops and compares every valid output.
module tb_fir_filter;

    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int NUM_TAPS = 7;
    localparam int OUT_W    = 48;

    typedef struct {
        longint value;
        longint cycle;
        string  name;
    } exp_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_tvalid = 1'b0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tready;
    logic              m_tvalid;
    logic [OUT_W-1:0]  m_tdata;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb [$];

    longint imp_y  [8]  = '{1024, 2048, 3072, 4096, 3072, 2048, 1024, 0};
    longint step_y [10] = '{8388608, 25165824, 50331648, 83886080, 109051904,
                            125829120, 134217728, 134217728, 134217728, 134217728};
    longint tone_y [16] = '{8388608, 16777216, 16777216, 16777216, 8388608, 0, 0, 0,
                            0, 0, 0, 0, 0, 0, 0, 0};
    longint neg_y  [10] = '{-33554432, -100663296, -201326592, -335544320, -436207616,
                            -503316480, -536870912, -536870912, -536870912, -536870912};

    fir_filter #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .NUM_TAPS(NUM_TAPS),
        .OUT_W   (OUT_W)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready),
        .s_axis_data_tdata (s_tdata),
        .m_axis_data_tvalid(m_tvalid),
        .m_axis_data_tdata (m_tdata)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one sample for exactly one edge; its result is due at the negedge after edge+2.
    task automatic send(input logic [DATA_W-1:0] x, input longint y, input string tag);
        exp_t e;
        @(posedge aclk);
        #2;
        s_tvalid = 1'b1;
        s_tdata  = x;
        e.value  = y;
        e.cycle  = longint'(cyc) + 3;
        e.name   = tag;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge aclk);
        #2;
        s_tvalid = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic apply_reset(input string tag);
        @(posedge aclk);
        #2;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        sb.delete();
        repeat (2) begin
            @(negedge aclk);
            check({tag, " rst tready"}, longint'(s_tready), 0);
            check({tag, " rst m_tvalid"}, longint'(m_tvalid), 0);
            check({tag, " rst m_tdata"}, longint'(m_tdata), 0);
        end
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(negedge aclk);
        check({tag, " tready before sync edge"}, longint'(s_tready), 0);
        @(negedge aclk);
        check({tag, " tready after release"}, longint'(s_tready), 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check({tag, " outstanding results"}, longint'(sb.size()), 0);
    endtask

    // Monitor: every valid output must match the oldest expected entry, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (m_tvalid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: tvalid=1 with nothing expected, tdata=%0d",
                             longint'($signed(m_tdata)));
                end else begin
                    e = sb.pop_front();
                    check({e.name, " data"}, longint'($signed(m_tdata)), e.value);
                    check({e.name, " cycle"}, longint'(cyc), e.cycle);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset("por");

        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? DATA_W'(1) : '0, imp_y[i], $sformatf("impulse[%0d]", i));
        end
        idle();
        drain("impulse");

        apply_reset("pre_step");
        for (int i = 0; i < 10; i++) begin
            send(DATA_W'(16'h2000), step_y[i], $sformatf("step[%0d]", i));
        end
        idle();
        drain("step");

        apply_reset("pre_tone");
        for (int i = 0; i < 16; i++) begin
            logic [DATA_W-1:0] x;
            case (i % 4)
                0:       x = DATA_W'(8192);
                2:       x = DATA_W'(-8192);
                default: x = '0;
            endcase
            send(x, tone_y[i], $sformatf("tone[%0d]", i));
        end
        idle();
        drain("tone");

        apply_reset("pre_neg");
        for (int i = 0; i < 10; i++) begin
            send(DATA_W'(-32768), neg_y[i], $sformatf("negfs[%0d]", i));
        end
        idle();
        drain("negfs");

        apply_reset("pre_gap");
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? DATA_W'(1) : '0, imp_y[i], $sformatf("gapped[%0d]", i));
            idle();
        end
        drain("gapped");

        send(DATA_W'(1), 1024, "inflight[0]");
        send('0, 2048, "inflight[1]");
        send('0, 3072, "inflight[2]");
        apply_reset("midstream");
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? DATA_W'(1) : '0, imp_y[i], $sformatf("restart[%0d]", i));
        end
        idle();
        drain("restart");

        repeat (4) @(negedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
